// File: rtl/multicycle_rca_pkg.sv
// Shared definitions for the multi-cycle ripple-carry adder/subtractor:
// FSM state encoding, default geometry and slice-count helpers.
package multicycle_rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 4;

  function automatic int num_slices(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice index counter needs at least one bit even when there is one slice.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multicycle_rca_chunk.sv
// Combinational CHUNK-bit ripple adder from full-adder cells; also exports the
// carry into its top bit so the caller can form signed overflow.
module multicycle_rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_top
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[CHUNK];
  assign c_top = c[CHUNK - 1];

endmodule

// File: rtl/multicycle_rca.sv
// Sequential WIDTH-bit add/subtract, one CHUNK slice per clock; result after
// N cycles from accept. start is ignored while busy; results hold until the next completion.
module multicycle_rca
  import multicycle_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int N    = num_slices(WIDTH, CHUNK);
  localparam int IDXW = idx_bits(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
  logic             carry;
  logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
  logic             slice_co, slice_c_top;
  logic             accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == LAST_IDX);

  always_comb begin
    slice_a = op_a[int'(idx) * CHUNK +: CHUNK];
    slice_b = op_b[int'(idx) * CHUNK +: CHUNK];
    acc_nxt = acc;
    acc_nxt[int'(idx) * CHUNK +: CHUNK] = slice_sum;
  end

  multicycle_rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca_chunk (
    .a     (slice_a),
    .b     (slice_b),
    .ci    (carry),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_top (slice_c_top)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtraction is a + ~b + 1: invert b once at accept and force carry-in high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : ci;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= slice_co;
      idx   <= idx + 1'b1;
      if (last) begin
        s   <= acc_nxt;
        co  <= slice_co;
        ovf <= slice_c_top ^ slice_co;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_rca.sv
// Bench for multicycle_rca: arithmetic reference model plus directed and
// random handshake traffic, with a second instance for the single-slice case.
module tb_multicycle_rca;

  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0, ci = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, co, ovf;
  logic [W-1:0] s;

  logic         start4 = 1'b0, sub4 = 1'b0, ci4 = 1'b0;
  logic [3:0]   a4 = '0, b4 = '0;
  logic         busy4, done4, co4, ovf4;
  logic [3:0]   s4;

  int vectors = 0;
  int miscompares = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_rca #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  multicycle_rca #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .ci(ci4),
    .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  // Reference: unsigned arithmetic gives s/co, signed arithmetic gives ovf.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c_in, input logic do_sub);
    longint ux, uy, sx, sy, ur, sr;
    logic   r_co, r_ovf;
    logic [W-1:0] r_s;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (do_sub) begin
      ur   = ux - uy;
      sr   = sx - sy;
      r_co = (ux >= uy);
    end else begin
      ur   = ux + uy + longint'(c_in);
      sr   = sx + sy + longint'(c_in);
      r_co = (ur >= (longint'(1) << W));
    end
    r_s   = ur[W-1:0];
    r_ovf = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    return {r_ovf, r_co, r_s};
  endfunction

  logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_ovf = 1'b0;
  logic [W-1:0] m_s = '0;
  logic         p_co = 1'b0, p_ovf = 1'b0;
  logic [W-1:0] p_s = '0;
  int           m_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_s = '0; m_co = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_s = p_s; m_co = p_co; m_ovf = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_cnt  = N;
        {p_ovf, p_co, p_s} = ref_op(a, b, ci, sub);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({busy, done, co, ovf, s} !== {m_busy, m_done, m_co, m_ovf, m_s}) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b s=%h co=%b ovf=%b want busy=%b done=%b s=%h co=%b ovf=%b",
                 $time, busy, done, s, co, ovf, m_busy, m_done, m_s, m_co, m_ovf);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done after %0d cycles want %0d", lat, N);
    end
  endtask

  task automatic scramble();
    a   = $urandom;
    b   = $urandom;
    ci  = ($urandom_range(0, 1) != 0);
    sub = ($urandom_range(0, 1) != 0);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tci, input logic tsub, output int lat);
    @(posedge clk); #2;
    a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    scramble();
    wait_done(lat);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, pulses;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("idle_busy", busy, 0);
    chk("idle_s", s, 0);

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("cout_lat", lat, N);
    chk("cout_s", s, 32'h0000_0000);
    chk("cout_co", co, 1);
    chk("cout_ovf", ovf, 0);

    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    chk("sovf_s", s, 32'h8000_0000);
    chk("sovf_co", co, 0);
    chk("sovf_ovf", ovf, 1);

    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, lat);
    chk("ci_s", s, 32'h2345_678A);
    chk("ci_co", co, 0);
    chk("ci_ovf", ovf, 0);

    // Back-to-back: start held through DONE, second operand set while done is high.
    @(posedge clk); #2;
    a = 32'd5; b = 32'd7; ci = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    wait_done(lat);
    chk("sub1_s", s, 32'hFFFF_FFFE);
    chk("sub1_co", co, 0);
    chk("sub1_ovf", ovf, 0);
    a = 32'h8000_0000; b = 32'h0000_0001;
    @(posedge clk); #2;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    scramble();
    wait_done(lat);
    chk("b2b_gap", lat + 1, N + 1);
    chk("sub2_s", s, 32'h7FFF_FFFF);
    chk("sub2_co", co, 1);
    chk("sub2_ovf", ovf, 1);

    // start pulsed mid-RUN must be ignored.
    @(posedge clk); #2;
    scramble(); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      if (done) pulses++;
      @(posedge clk); #2;
    end
    chk("run_start_pulses", pulses, 1);

    // Reset at RUN cycle 3 aborts the operation.
    @(posedge clk); #2;
    scramble(); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_s", s, 0);
    chk("abort_co", co, 0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (done) pulses++;
      @(posedge clk); #2;
    end
    chk("abort_pulses", pulses, 0);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) == 0);
      a   = pick();
      b   = pick();
      ci  = ($urandom_range(0, 1) != 0);
      sub = ($urandom_range(0, 1) != 0);
    end
    start = 1'b0;
    repeat (N + 2) @(posedge clk);
    #2;

    // Single-slice geometry.
    a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #2;
    start4 = 1'b0;
    chk("w4_busy", busy4, 1);
    chk("w4_done_early", done4, 0);
    @(posedge clk); #2;
    chk("w4_done", done4, 1);
    chk("w4_s", s4, 4'h0);
    chk("w4_co", co4, 1);
    chk("w4_ovf", ovf4, 0);
    @(posedge clk); #2;
    chk("w4_done_pulse", done4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
